matrix_transpose_seq: RTL and testbench
=======================================

Name: matrix_transpose_seq

Overview:
- Sequencing controller for the 2x2 matrix transpose datapath.
- Accepts a 2x2 matrix serially, one element per cycle, row-major, over a valid/ready stream and stores it in a 4-entry register bank.
- Emits the transposed matrix serially, row-major, over a second valid/ready stream.
- Sits between a serial element producer and any serial consumer; no back-to-back overlap (single buffer).

Parameters:
- W, 3, element width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has an element on in_data.
- in_data  input  W  matrix element, row-major order a11, a12, a21, a22.
- in_ready  output  1  controller can accept an element this cycle.
- out_valid  output  1  out_data holds a valid transposed element.
- out_data  output  W  transposed element, row-major order t11, t12, t21, t22.
- out_last  output  1  high with the 4th (t22) output element.
- out_ready  input  1  consumer accepts out_data this cycle.
- busy  output  1  high when not in LOAD with idx=0.

Behaviour:
- Reset (rst=1 at clk edge): state=LOAD, idx=0, all four element registers=0.
  - Resulting outputs: in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0.
  - Reset wins over any handshake in the same cycle; a partially loaded or partially emitted matrix is discarded.
- State machine has two states:
  - LOAD: in_ready=1, out_valid=0.
    - On in_valid&&in_ready, write in_data to register[idx] and increment idx.
    - On the accept with idx=3: idx->0, next state EMIT.
  - EMIT: in_ready=0, out_valid=1.
    - out_data is a combinational mux of the registers through the transpose mapping (t11=a11, t12=a21, t21=a12, t22=a22), selected by idx.
    - Emission order is therefore a11, a21, a12, a22.
    - out_last = (idx==3).
    - On out_valid&&out_ready, idx increments.
    - On the transfer with idx=3: idx->0, next state LOAD.
- idx is 2 bits and wraps 3->0 only on the final handshake of each phase.
- Latency:
  - First output valid the cycle after the 4th input accept.
  - Minimum round trip is 8 cycles per matrix (4 load + 4 emit) with in_valid and out_ready tied high.
- Stall rules:
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
  - in_valid low in LOAD simply holds idx.
- in_data arriving in EMIT is not accepted; the producer must hold it until in_ready returns.
- No arithmetic is performed; widths are W throughout, no truncation.

Optional Feature:
- Macro MTX_BYPASS_EN.
- Defined:
  - Adds input port bypass (1 bit).
  - bypass is sampled into a mode register on the first element accept of each matrix (LOAD, idx=0).
  - If the mode register is 1, EMIT outputs the original order a11, a12, a21, a22 instead of the transposed order.
  - Reset clears the mode register to 0.
- Undefined: the port and mode register are absent; output is always transposed.

Decomposition:
- Shared package mtx_pkg holds:
  - the element width constant MTX_W=3;
  - the state enum (LOAD, EMIT);
  - the element count constant MTX_N=4;
  - the index typedef (2 bits).
- Natural sub-module: the existing combinational matrix_transpose_2x2, instantiated on the register bank. Its four outputs feed the idx-selected output mux.

Test Plan:
- Reset then stream 1,2,3,4 with in_valid=1 and out_ready=1 -> outputs 1,3,2,4 on consecutive cycles starting 1 cycle after the 4th accept; out_last only with 4; busy drops after the last transfer.
- Stream 5,6,7,0 with out_ready low for 3 cycles at the first output -> out_data stays 5 and out_valid stays 1 during the stall; then 5,7,6,0 follow.
- in_valid gaps (1,0,1,0,...) while loading 7,7,1,2 -> idx advances only on accepts; output is 7,1,7,2; in_ready is 0 throughout EMIT even with in_valid=1.
- Two back-to-back matrices (1,2,3,4 then 4,3,2,1) -> 1,3,2,4 then 4,2,3,1; the second matrix's first element is accepted the cycle after the first matrix's out_last transfer.
- Assert rst after 2 outputs of matrix 6,5,4,3 -> next cycle out_valid=0, in_ready=1, registers 0; a new matrix 1,2,3,4 produces 1,3,2,4.
- MTX_BYPASS_EN defined, bypass=1 on the first element of 1,2,3,4 and 0 thereafter -> output 1,2,3,4; next matrix with bypass=0 -> transposed order.

Source files
------------

// File: rtl/mtx_pkg.sv
// Shared types and constants for the 2x2 matrix transpose sequencer.
package mtx_pkg;

  localparam int MTX_W = 3;
  localparam int MTX_N = 4;

  typedef logic [1:0] idx_t;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_t;

  function automatic idx_t idx_inc(input idx_t i);
    return i + idx_t'(1);
  endfunction

endpackage

// File: rtl/matrix_transpose_2x2.sv
// Combinational 2x2 transpose: swaps the off-diagonal elements.
module matrix_transpose_2x2 #(
  parameter int W = 3
) (
  input  logic [W-1:0] a11,
  input  logic [W-1:0] a12,
  input  logic [W-1:0] a21,
  input  logic [W-1:0] a22,
  output logic [W-1:0] t11,
  output logic [W-1:0] t12,
  output logic [W-1:0] t21,
  output logic [W-1:0] t22
);

  assign t11 = a11;
  assign t12 = a21;
  assign t21 = a12;
  assign t22 = a22;

endmodule

// File: rtl/matrix_transpose_seq.sv
// Serial 2x2 matrix transpose sequencer: loads four elements, emits the transpose.
// Optional macro MTX_BYPASS_EN adds a per-matrix bypass (original order) input.
//
// state | meaning
// LOAD  | accepting elements a11..a22 into the bank, idx = write slot
// EMIT  | presenting transposed elements, idx = read slot
module matrix_transpose_seq
  import mtx_pkg::*;
#(
  parameter int W = MTX_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready,
`ifdef MTX_BYPASS_EN
  input  logic         bypass,
`endif
  output logic         busy
);

  state_t       state;
  state_t       state_nxt;
  idx_t         idx;
  logic [W-1:0] bank [MTX_N];
  logic [W-1:0] t11, t12, t21, t22;
  logic [W-1:0] sel [MTX_N];
  logic         last_idx;
  logic         in_fire;
  logic         out_fire;
`ifdef MTX_BYPASS_EN
  logic         mode;
`endif

  assign last_idx = (idx == idx_t'(MTX_N - 1));
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && last_idx) state_nxt = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && last_idx) state_nxt = LOAD;
      end
    endcase
  end

  // idx wraps 3->0 on its own, which lands exactly on the final handshake of each phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      for (int i = 0; i < MTX_N; i++) bank[i] <= '0;
`ifdef MTX_BYPASS_EN
      mode <= 1'b0;
`endif
    end else if (in_fire) begin
      bank[idx] <= in_data;
      idx       <= idx_inc(idx);
`ifdef MTX_BYPASS_EN
      if (idx == '0) mode <= bypass;
`endif
    end else if (out_fire) begin
      idx <= idx_inc(idx);
    end
  end

  matrix_transpose_2x2 #(.W(W)) u_transpose (
    .a11 (bank[0]),
    .a12 (bank[1]),
    .a21 (bank[2]),
    .a22 (bank[3]),
    .t11 (t11),
    .t12 (t12),
    .t21 (t21),
    .t22 (t22)
  );

  always_comb begin
    sel[0] = t11;
    sel[1] = t12;
    sel[2] = t21;
    sel[3] = t22;
`ifdef MTX_BYPASS_EN
    if (mode) begin
      for (int i = 0; i < MTX_N; i++) sel[i] = bank[i];
    end
`endif
  end

  // Output is forced to zero outside EMIT so idle/reset shows a clean bus.
  assign out_data = (state == EMIT) ? sel[idx] : '0;
  assign out_last = out_valid & last_idx;
  assign busy     = (state != LOAD) || (idx != '0);

endmodule

// File: tb/tb_matrix_transpose_seq.sv
// Self-checking bench: per-cycle compare against a queue-based transpose model plus literal pins.
module tb_matrix_transpose_seq;
  import mtx_pkg::*;

  localparam int W = MTX_W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         out_ready = 1'b1;
  logic         busy;
`ifdef MTX_BYPASS_EN
  logic         bypass = 1'b0;
  bit           byp_rand = 1'b0;
  bit           byp_next = 1'b0;
`endif

  always #5 clk = ~clk;

  matrix_transpose_seq #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
`ifdef MTX_BYPASS_EN
    .bypass    (bypass),
`endif
    .busy      (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: elements collected per matrix, transposed output queue.
  int in_buf[$];
  int exp_out[$];
  int m_mode = 0;
  int got[$];
  bit armed = 1'b0;

  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", in_ready, exp_out.size() == 0);
      chk("out_valid", out_valid, exp_out.size() != 0);
      chk("busy", busy, (in_buf.size() != 0) || (exp_out.size() != 0));
      if (exp_out.size() != 0) begin
        chk("out_data", out_data, exp_out[0]);
        chk("out_last", out_last, exp_out.size() == 1);
      end else begin
        chk("out_last_idle", out_last, 0);
      end
    end
    if (rst) begin
      in_buf.delete();
      exp_out.delete();
      m_mode = 0;
    end else begin
      if (out_valid && out_ready) got.push_back(int'(out_data));
      if (exp_out.size() != 0) begin
        if (out_ready) void'(exp_out.pop_front());
      end else if (in_valid) begin
`ifdef MTX_BYPASS_EN
        if (in_buf.size() == 0) m_mode = int'(bypass);
`endif
        in_buf.push_back(int'(in_data));
        if (in_buf.size() == 4) begin
          for (int k = 0; k < 4; k++) begin
            int r, c;
            r = k / 2;
            c = k % 2;
            exp_out.push_back((m_mode != 0) ? in_buf[k] : in_buf[2 * c + r]);
          end
          in_buf.delete();
        end
      end
    end
  end

  // Stimulus driver state
  int src[$];
  int vmode = 0;
  int rmode = 0;
  int stall = 0;
  bit tgl = 1'b0;

  task automatic drive();
    in_valid = (src.size() > 0) &&
               ((vmode == 0) || (vmode == 1 && tgl) || (vmode == 2 && $urandom_range(0, 1) == 1));
    in_data  = (src.size() > 0) ? W'(src[0]) : W'($urandom);
`ifdef MTX_BYPASS_EN
    if (byp_rand) bypass = 1'($urandom_range(0, 1));
    else          bypass = (src.size() > 0 && src.size() % 4 == 0) ? byp_next : 1'b0;
`endif
    if (stall > 0 && out_valid) begin
      out_ready = 1'b0;
      stall--;
    end else begin
      out_ready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic step();
    bit acc;
    @(negedge clk);
    acc = !rst && in_valid && in_ready;
    @(posedge clk);
    #1;
    if (acc) void'(src.pop_front());
    tgl = ~tgl;
    drive();
  endtask

  task automatic run_to_idle(input string nm, input int budget);
    int n;
    n = 0;
    drive();
    while ((src.size() != 0 || in_buf.size() != 0 || exp_out.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk({"timeout_", nm}, n < budget, 1);
  endtask

  task automatic pin(input string nm, input int base, input int e[$]);
    chk({nm, "_count"}, got.size() - base, e.size());
    if (got.size() - base == e.size()) begin
      foreach (e[k]) chk({nm, "_elem"}, got[base + k], e[k]);
    end
  endtask

  initial begin
    int base;
    int n;
    int eq[$];

    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    armed = 1'b1;

    // Straight stream
    base = got.size();
    src = {1, 2, 3, 4};
    run_to_idle("t1", 40);
    eq = {1, 3, 2, 4};
    pin("t1", base, eq);

    // Consumer stall on the first output
    base = got.size();
    src = {5, 6, 7, 0};
    stall = 3;
    run_to_idle("t2", 40);
    eq = {5, 7, 6, 0};
    pin("t2", base, eq);

    // Producer gaps
    base = got.size();
    vmode = 1;
    src = {7, 7, 1, 2};
    run_to_idle("t3", 40);
    eq = {7, 1, 7, 2};
    pin("t3", base, eq);

    // Back-to-back matrices
    base = got.size();
    vmode = 0;
    src = {1, 2, 3, 4, 4, 3, 2, 1};
    run_to_idle("t4", 60);
    eq = {1, 3, 2, 4, 4, 2, 3, 1};
    pin("t4", base, eq);

    // Reset in the middle of emission
    base = got.size();
    src = {6, 5, 4, 3};
    drive();
    n = 0;
    while (got.size() < base + 2 && n < 40) begin
      step();
      n++;
    end
    chk("timeout_t5", n < 40, 1);
    eq = {6, 4};
    pin("t5_pre", base, eq);
    rst = 1'b1;
    src.delete();
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("t5_in_ready", in_ready, 1);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_data", out_data, 0);
    chk("t5_busy", busy, 0);
    base = got.size();
    src = {1, 2, 3, 4};
    run_to_idle("t5", 40);
    eq = {1, 3, 2, 4};
    pin("t5", base, eq);

`ifdef MTX_BYPASS_EN
    base = got.size();
    byp_next = 1'b1;
    src = {1, 2, 3, 4};
    run_to_idle("t6a", 40);
    eq = {1, 2, 3, 4};
    pin("t6a", base, eq);
    base = got.size();
    byp_next = 1'b0;
    src = {1, 2, 3, 4};
    run_to_idle("t6b", 40);
    eq = {1, 3, 2, 4};
    pin("t6b", base, eq);
    byp_rand = 1'b1;
`endif

    // Randomized traffic, gaps and back-pressure
    vmode = 2;
    rmode = 1;
    for (int m = 0; m < 25 * 4; m++) src.push_back(int'($urandom_range(0, (1 << W) - 1)));
    run_to_idle("rand", 3000);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
